// File: rtl/m_scale_bias_loader.sv
// Double-buffered fp16 scale/bias loader: words stream into a shadow bank while the
// active bank drives the elementwise stage; a consumer-timed swap commits the shadow set.
module m_scale_bias_loader #(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [15:0]                          in_data,
  input  logic                                 swap_req,
  output logic [ROWS-1:0][COLS-1:0][1:0][15:0] scaleMM,
  output logic [ROWS-1:0][COLS-1:0][15:0]      biasMM,
  output logic                                 params_valid,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err
);

  localparam int RC     = ROWS * COLS;
  localparam int NWORDS = 3 * RC;
  localparam int IDX_W  = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  logic [1:0]                           state_q, state_d;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic [NWORDS-1:0][15:0]              shadow_q, shadow_d;
  logic [ROWS-1:0][COLS-1:0][1:0][15:0] scale_q, scale_d;
  logic [ROWS-1:0][COLS-1:0][15:0]      bias_q, bias_d;
  logic                                 pv_q, pv_d;
  logic                                 done_q, done_d;
  logic                                 err_q, err_d;
  logic                                 accept;

  assign in_ready = (state_q == ST_LOAD);
  // abort outranks data: a word presented alongside abort is never taken.
  assign accept   = in_valid & in_ready & ~abort;
  assign busy     = (state_q != ST_IDLE);

  // The shadow bank is kept flat in arrival order; the plane/row/col split
  // happens only on the copy into the active bank.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    scale_d  = scale_q;
    bias_d   = bias_q;
    pv_d     = pv_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          err_d = start;
          if (accept) begin
            shadow_d[idx_q] = in_data;
            if (idx_q == LAST_IDX) begin
              state_d = ST_FULL;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      ST_FULL: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          err_d = start;
          if (swap_req) begin
            for (int r = 0; r < ROWS; r++) begin
              for (int c = 0; c < COLS; c++) begin
                scale_d[r][c][0] = shadow_q[r*COLS + c];
                scale_d[r][c][1] = shadow_q[RC + r*COLS + c];
                bias_d[r][c]     = shadow_q[2*RC + r*COLS + c];
              end
            end
            pv_d    = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      scale_q  <= '0;
      bias_q   <= '0;
      pv_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      scale_q  <= scale_d;
      bias_q   <= bias_d;
      pv_q     <= pv_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Active bank registers feed the array directly, bits untouched.
  assign scaleMM      = scale_q;
  assign biasMM       = bias_q;
  assign params_valid = pv_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_m_scale_bias_loader.sv
// Bench for m_scale_bias_loader: directed and randomized loads checked every cycle
// against a queue-based model of the parameter-set rules.
module tb_m_scale_bias_loader;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int RC   = ROWS * COLS;
  localparam int NW   = 3 * RC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        swap_req = 1'b0;
  logic        in_ready, params_valid, busy, done, err;
  logic [ROWS-1:0][COLS-1:0][1:0][15:0] scaleMM;
  logic [ROWS-1:0][COLS-1:0][15:0]      biasMM;

  m_scale_bias_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .swap_req(swap_req), .scaleMM(scaleMM), .biasMM(biasMM),
    .params_valid(params_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: mode 0 = nothing pending, 1 = collecting words, 2 = complete set waiting.
  int          m_mode = 0;
  logic [15:0] m_words[$];
  logic [15:0] m_act[NW];
  bit          m_pv = 0, m_done = 0, m_err = 0;

  initial begin
    foreach (m_act[i]) m_act[i] = 16'h0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_mode = 0; m_words.delete();
        foreach (m_act[i]) m_act[i] = 16'h0;
        m_pv = 0; m_done = 0; m_err = 0;
      end else begin
        m_done = 0; m_err = 0;
        if (abort) begin
          m_mode = 0; m_words.delete();
        end else if (m_mode == 0) begin
          if (start) begin m_mode = 1; m_words.delete(); end
        end else if (m_mode == 1) begin
          if (start) m_err = 1;
          if (in_valid) begin
            m_words.push_back(in_data);
            if (m_words.size() == NW) m_mode = 2;
          end
        end else begin
          if (start) m_err = 1;
          if (swap_req) begin
            for (int k = 0; k < NW; k++) m_act[k] = m_words[k];
            m_done = 1; m_pv = 1; m_mode = 0;
          end
        end
      end
    end
  end

  // Word k belongs to plane k/RC, row (k%RC)/COLS, col k%COLS.
  initial begin
    logic [ROWS-1:0][COLS-1:0][1:0][15:0] e_scale;
    logic [ROWS-1:0][COLS-1:0][15:0]      e_bias;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) begin
            e_scale[r][c][0] = m_act[r*COLS + c];
            e_scale[r][c][1] = m_act[RC + r*COLS + c];
            e_bias[r][c]     = m_act[2*RC + r*COLS + c];
          end
        chk("scaleMM", scaleMM, e_scale);
        chk("biasMM", biasMM, e_bias);
        chk("params_valid", params_valid, m_pv);
        chk("in_ready", in_ready, (m_mode == 1));
        chk("busy", busy, (m_mode != 0));
        chk("done", done, m_done);
        chk("err", err, m_err);
      end
    end
  end

  logic [15:0] wsrc[NW];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_swap();
    swap_req = 1'b1; cyc(); swap_req = 1'b0;
  endtask

  // gaps: 0 none, 1 random, 2 toggling with a 5-cycle hole
  task automatic load(input int n, input int gaps, input int err_at, input bit swap_last);
    int  k = 0;
    int  budget = 0;
    bit  acc;
    bit  err_sent = 0;
    while (k < n && budget < 1000) begin
      case (gaps)
        1:       in_valid = ($urandom_range(0, 2) != 0);
        2:       in_valid = (budget % 2 == 0) && !(budget >= 20 && budget < 25);
        default: in_valid = 1'b1;
      endcase
      in_data  = wsrc[k];
      start    = (k == err_at) && !err_sent;
      if (start) err_sent = 1;
      swap_req = swap_last && (k == n - 1) && in_valid;
      acc      = in_valid && in_ready;
      cyc();
      if (acc) k++;
      budget++;
    end
    in_valid = 1'b0; start = 1'b0; swap_req = 1'b0;
    chk("load_words_taken", k, n);
  endtask

  task automatic fill_ramp(input logic [15:0] base);
    for (int k = 0; k < NW; k++) wsrc[k] = base + 16'(k);
  endtask

  initial begin
    logic [ROWS-1:0][COLS-1:0][1:0][15:0] all_s;
    logic [ROWS-1:0][COLS-1:0][15:0]      all_b;

    // 1: asynchronous reset asserted mid-cycle
    cyc(); cyc();
    #3 rst = 1'b1;
    #1;
    chk("rst_scale", scaleMM, '0);
    chk("rst_bias", biasMM, '0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pv", params_valid, 1'b0);
    chk("rst_done_err", {done, err}, 2'b00);
    @(posedge clk); #1 rst = 1'b0;
    chk_on = 1'b1;
    cyc();

    // 2: ramp load without gaps, swap two cycles after the last word
    fill_ramp(16'h3C00);
    pulse_start();
    load(NW, 0, -1, 0);
    cyc(); cyc();
    do_swap();
    chk("t2_done", done, 1'b1);
    chk("t2_s120", scaleMM[1][2][0], 16'h3C06);
    chk("t2_s121", scaleMM[1][2][1], 16'h3C16);
    chk("t2_b33", biasMM[3][3], 16'h3C2F);
    cyc();
    chk("t2_done_clr", done, 1'b0);
    chk("t2_pv", params_valid, 1'b1);

    // 3: toggling valid with a gap; extra word offered while full
    fill_ramp(16'h3C00);
    pulse_start();
    load(NW, 2, -1, 0);
    in_valid = 1'b1; in_data = 16'hDEAD;
    cyc(); cyc(); cyc();
    chk("t3_full_not_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    do_swap();
    chk("t3_b33", biasMM[3][3], 16'h3C2F);
    chk("t3_s000", scaleMM[0][0][0], 16'h3C00);

    // 4: partial load then abort keeps the active bank; then all-4000 set
    fill_ramp(16'h5000);
    pulse_start();
    load(20, 0, -1, 0);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("t4_abort_idle", busy, 1'b0);
    chk("t4_keep", scaleMM[1][2][0], 16'h3C06);
    for (int k = 0; k < NW; k++) wsrc[k] = 16'h4000;
    pulse_start();
    load(NW, 0, -1, 0);
    do_swap();
    all_s = {(ROWS*COLS*2){16'h4000}};
    all_b = {(ROWS*COLS){16'h4000}};
    chk("t4_all_scale", scaleMM, all_s);
    chk("t4_all_bias", biasMM, all_b);

    // 5: start during load raises err; swap on the last-word cycle is ignored
    fill_ramp(16'h7C00);
    pulse_start();
    load(NW, 0, 10, 1);
    chk("t5_not_yet", scaleMM[0][0][0], 16'h4000);
    do_swap();
    chk("t5_commit", scaleMM[0][0][0], 16'h7C00);
    chk("t5_b33", biasMM[3][3], 16'h7C2F);

    // 6: reset in the middle of a load
    fill_ramp(16'h1234);
    pulse_start();
    load(30, 0, -1, 0);
    #3 rst = 1'b1;
    #1;
    chk("t6_pv", params_valid, 1'b0);
    chk("t6_scale0", scaleMM, '0);
    chk("t6_busy", busy, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    cyc();
    pulse_start();
    load(NW, 1, -1, 0);
    do_swap();
    chk("t6_b33", biasMM[3][3], 16'h1263);

    // 7: randomized sets with random aborts, spurious starts and swap delays
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < NW; k++) wsrc[k] = 16'($urandom);
      swap_req = ($urandom_range(0, 1) == 1);
      cyc();
      swap_req = 1'b0;
      pulse_start();
      if ($urandom_range(0, 3) == 0) begin
        load($urandom_range(1, NW - 1), 1, -1, 0);
        abort = 1'b1; start = ($urandom_range(0, 1) == 1); cyc();
        abort = 1'b0; start = 1'b0;
      end else begin
        load(NW, 1, $urandom_range(0, 60), 0);
        for (int d = $urandom_range(0, 4); d > 0; d--) begin
          in_valid = ($urandom_range(0, 1) == 1);
          in_data  = 16'($urandom);
          start    = ($urandom_range(0, 3) == 0);
          cyc();
        end
        in_valid = 1'b0; start = 1'b0;
        do_swap();
      end
      cyc();
    end

    cyc(); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
